umi_tx_arb: RTL and testbench

UMI_TX_ARB -- requirements
Module: umi_tx_arb

---
 rtl/umi_tx_arb.sv | 125 ++++++++++++
 tb/tb_umi_tx_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_tx_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// umi_tx_arb
// Merges NPORTS UMI transmit sources into one UMI transmit stream.
// A round-robin pointer picks the first valid source at or after the pointer.
// The merged packet is held in a one-entry output register, so a packet that
// is accepted on one clock edge appears on the output after that edge.
// When a packet is accepted, the pointer moves to the slot after the winner.
//
// Ports
//   clk            clock; all state changes on its rising edge
//   rst            synchronous active-high reset
//   in_packet      source packets, source i occupies [i*PW +: PW]
//   in_valid       per-source valid
//   in_ready       per-source ready; only the granted source can see a 1
//   umi_packet_tx  merged packet toward the UMI TX sink
//   umi_valid_tx   merged valid
//   umi_ready_tx   sink ready
//   pkt_count      running count of accepted packets; wraps at 2^32
// -----------------------------------------------------------------------------
module umi_tx_arb #(
    parameter int NPORTS = 4,
    parameter int PW     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS*PW-1:0] in_packet,
    input  logic [NPORTS-1:0]    in_valid,
    output logic [NPORTS-1:0]    in_ready,
    output logic [PW-1:0]        umi_packet_tx,
    output logic                 umi_valid_tx,
    input  logic                 umi_ready_tx,
    output logic [31:0]          pkt_count
);

    localparam int              PTRW     = $clog2(NPORTS);
    // One extra bit holds ptr+k (at most 2*NPORTS-2) before it is folded back.
    localparam logic [PTRW:0]   NPORTS_W = (PTRW+1)'(NPORTS);
    localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NPORTS - 1);

    logic [PTRW-1:0] ptr_q;
    logic [PTRW-1:0] ptr_d;
    logic [PW-1:0]   pkt_q;
    logic [PW-1:0]   pkt_d;
    logic            valid_q;
    logic            valid_d;
    logic [31:0]     cnt_q;
    logic [31:0]     cnt_d;

    logic            out_free_s;
    logic            gnt_found_s;
    logic [PTRW-1:0] gnt_idx_s;
    logic [PTRW:0]   sum_s;
    logic [PTRW:0]   cand_s;
    logic            xfer_s;

    // Rotating first-valid search that starts at the round-robin pointer
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = 0; k < NPORTS; k++) begin
            sum_s       = {1'b0, ptr_q} + (PTRW+1)'(k);
            cand_s      = (sum_s >= NPORTS_W) ? (sum_s - NPORTS_W) : sum_s;
            // The first hit in search order wins; later hits cannot override it.
            gnt_idx_s   = (!gnt_found_s && in_valid[cand_s[PTRW-1:0]]) ? cand_s[PTRW-1:0] : gnt_idx_s;
            gnt_found_s = gnt_found_s | in_valid[cand_s[PTRW-1:0]];
        end
    end

    // The output slot can take a packet when it is empty or is being drained now.
    // Keeping rst in xfer_s forces every ready low during the reset cycle.
    assign out_free_s = ~valid_q | umi_ready_tx;
    assign xfer_s     = gnt_found_s & out_free_s & ~rst;

    // Ready goes to the granted source only; it never depends on packet contents
    always_comb begin
        in_ready = '0;
        if (xfer_s) begin
            in_ready[gnt_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Next state for the output slot, the pointer and the packet counter
    always_comb begin
        ptr_d   = ptr_q;
        pkt_d   = pkt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (xfer_s) begin
            pkt_d   = in_packet[int'(gnt_idx_s)*PW +: PW];
            valid_d = 1'b1;
            ptr_d   = (gnt_idx_s == LAST_IDX) ? '0 : (gnt_idx_s + PTRW'(1));
            cnt_d   = cnt_q + 32'd1;
        end else if (umi_ready_tx) begin
            valid_d = 1'b0;
        end else begin
            // Stalled or idle: hold the packet, the valid flag and the pointer.
            valid_d = valid_q;
        end
    end

    // State registers; reset drops any held packet and restarts the pointer at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            ptr_q   <= ptr_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign umi_packet_tx = pkt_q;
    assign umi_valid_tx  = valid_q;
    assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_umi_tx_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_umi_tx_arb
// The stimulus process drives the inputs on the falling edge.
// The monitor process wakes 3 ns after the falling edge, when every value has
// settled before the next rising edge. It then does three things:
//   - it compares the DUT against an abstract model of arbiter state
//     (pointer, slot occupancy and count);
//   - it pushes each packet it expects to be accepted into a scoreboard queue;
//   - it checks that queue against the held output packet.
// -----------------------------------------------------------------------------
module tb_umi_tx_arb;

    localparam int NPORTS      = 4;
    localparam int PW          = 256;
    localparam int RAND_CYCLES = 20000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NPORTS*PW-1:0] in_packet;
    logic [NPORTS-1:0]    in_valid;
    logic [NPORTS-1:0]    in_ready;
    logic [PW-1:0]        umi_packet_tx;
    logic                 umi_valid_tx;
    logic                 umi_ready_tx;
    logic [31:0]          pkt_count;

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    umi_tx_arb #(.NPORTS(NPORTS), .PW(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_packet     (in_packet),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .umi_packet_tx (umi_packet_tx),
        .umi_valid_tx  (umi_valid_tx),
        .umi_ready_tx  (umi_ready_tx),
        .pkt_count     (pkt_count)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    int            m_ptr    = 0;
    logic          m_valid  = 1'b0;
    logic [31:0]   m_cnt    = 32'd0;
    bit            m_known  = 1'b0;
    int            waits[NPORTS];
    bit            preload_req  = 1'b0;
    bit            preload_done = 1'b0;
    bit            end_req      = 1'b0;
    bit            end_done     = 1'b0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid source searching ptr, ptr+1, ... modulo NPORTS
    function automatic int find_grant(input logic [NPORTS-1:0] v, input int p);
        for (int k = 0; k < NPORTS; k++) begin
            if (v[(p + k) % NPORTS]) return (p + k) % NPORTS;
        end
        return -1;
    endfunction

    // Reference model and scoreboard, evaluated on settled values before each rising edge
    always @(negedge clk) begin
        logic [NPORTS-1:0] exp_rdy;
        logic [NPORTS-1:0] acc;
        int                g;
        #3;
        if (preload_req && !preload_done) begin
            force dut.cnt_q = 32'hFFFF_FFFF;
            #1;
            release dut.cnt_q;
            m_cnt        = 32'hFFFF_FFFF;
            preload_done = 1'b1;
        end
        if (end_req && !end_done) begin
            chk("drain_empty", PW'(exp_q.size()), PW'(0));
            end_done = 1'b1;
        end
        if (rst) begin
            chk("ready_in_reset", PW'(in_ready), PW'(0));
            m_valid = 1'b0;
            m_ptr   = 0;
            m_cnt   = 32'd0;
            exp_q.delete();
            for (int i = 0; i < NPORTS; i++) waits[i] = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            chk("valid", PW'(umi_valid_tx), PW'(m_valid));
            chk("pkt_count", PW'(pkt_count), PW'(m_cnt));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", PW'(0), PW'(1));
                end else begin
                    chk("out_packet", umi_packet_tx, exp_q[0]);
                end
            end
            g       = find_grant(in_valid, m_ptr);
            exp_rdy = '0;
            if (g >= 0 && (!m_valid || umi_ready_tx)) exp_rdy[g] = 1'b1;
            chk("in_ready", PW'(in_ready), PW'(exp_rdy));
            if (m_valid && umi_ready_tx && exp_q.size() > 0) void'(exp_q.pop_front());
            // Starvation bound measured on the grants the DUT actually gives
            acc = in_valid & in_ready;
            if (acc != '0) begin
                for (int i = 0; i < NPORTS; i++) begin
                    if (acc[i]) begin
                        waits[i] = 0;
                    end else if (in_valid[i]) begin
                        waits[i]++;
                        chk("starvation_bound", PW'(waits[i] <= NPORTS - 1), PW'(1));
                    end else begin
                        waits[i] = 0;
                    end
                end
            end
            if (exp_rdy != '0) begin
                exp_q.push_back(in_packet[g*PW +: PW]);
                m_ptr   = (g + 1) % NPORTS;
                m_cnt   = m_cnt + 32'd1;
                m_valid = 1'b1;
            end else if (umi_ready_tx) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic reset_dut();
        rst          = 1'b1;
        in_valid     = '0;
        umi_ready_tx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [PW-1:0] rand_pkt(input int src, input int seq);
        logic [PW-1:0] p;
        for (int w = 0; w < PW / 32; w++) p[w*32 +: 32] = $urandom();
        p[31:0] = {16'(seq), 8'(src), 8'(seq)};
        return p;
    endfunction

    // Stimulus: directed scenarios followed by randomized hold-until-accepted traffic
    initial begin
        logic [NPORTS-1:0] acc;
        int                seq[NPORTS];
        rst          = 1'b1;
        in_valid     = '0;
        in_packet    = '0;
        umi_ready_tx = 1'b0;
        repeat (3) @(negedge clk);

        // Single packet from source 2 right after reset
        rst                      = 1'b0;
        in_valid                 = 4'b0100;
        in_packet[2*PW +: PW]    = 256'hA5;
        umi_ready_tx             = 1'b1;
        @(negedge clk);
        in_valid = '0;
        repeat (2) @(negedge clk);

        // All sources valid, sink always ready: 0,1,2,3,0,1,2,3
        reset_dut();
        umi_ready_tx = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NPORTS; i++) in_packet[i*PW +: PW] = rand_pkt(i, c);
            in_valid = 4'b1111;
            @(negedge clk);
        end
        in_valid = '0;
        repeat (2) @(negedge clk);

        // Output held by a stalled sink while sources 1 and 3 wait
        reset_dut();
        in_packet[0*PW +: PW] = rand_pkt(0, 1);
        in_valid              = 4'b0001;
        umi_ready_tx          = 1'b0;
        @(negedge clk);
        in_packet[1*PW +: PW] = rand_pkt(1, 1);
        in_packet[3*PW +: PW] = rand_pkt(3, 1);
        in_valid              = 4'b1010;
        repeat (5) @(negedge clk);
        umi_ready_tx = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = '0;
        repeat (2) @(negedge clk);

        // Counter wrap from 0xFFFFFFFF
        reset_dut();
        preload_req           = 1'b1;
        in_packet[1*PW +: PW] = rand_pkt(1, 7);
        in_valid              = 4'b0010;
        umi_ready_tx          = 1'b1;
        @(negedge clk);
        in_valid = '0;
        repeat (2) @(negedge clk);

        // Reset while a packet is held by a stalled sink
        reset_dut();
        in_packet[2*PW +: PW] = rand_pkt(2, 3);
        in_valid              = 4'b0100;
        umi_ready_tx          = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_valid = 4'b1111;
        @(negedge clk);
        rst          = 1'b0;
        umi_ready_tx = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = '0;
        @(negedge clk);

        // Randomized traffic; a source keeps its packet until it is accepted
        reset_dut();
        acc = '0;
        for (int i = 0; i < NPORTS; i++) seq[i] = 0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (acc[i] || !in_valid[i]) begin
                    if ($urandom_range(0, 99) < ((c < RAND_CYCLES / 2) ? 60 : 90)) begin
                        in_valid[i]           = 1'b1;
                        in_packet[i*PW +: PW] = rand_pkt(i, seq[i]);
                        seq[i]++;
                    end else begin
                        in_valid[i] = 1'b0;
                    end
                end
            end
            umi_ready_tx = ($urandom_range(0, 99) < ((c < RAND_CYCLES / 2) ? 70 : 35));
            #3;
            acc = in_valid & in_ready;
            @(negedge clk);
        end

        // Drain, then confirm nothing is left in the scoreboard
        in_valid     = '0;
        umi_ready_tx = 1'b1;
        repeat (4) @(negedge clk);
        end_req = 1'b1;
        repeat (2) @(negedge clk);
        if (!end_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_check: got not-run expected run");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
